bp_stream_gather: RTL and testbench

BP_STREAM_GATHER -- requirements
Module: bp_stream_gather

---
 rtl/bp_stream_gather_if.sv | 60 ++++++
 rtl/bp_stream_gather.sv | 144 ++++++++++++++
 tb/tb_bp_stream_gather.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_stream_gather_if.sv
// Configuration package and stream-gather bus: beat-serial input side, registered block output side.
// The slave modport is the gather engine; the master modport is whoever feeds beats and drains blocks.
package bp_stream_gather_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg, e_bp_unicore_cfg} bp_params_e;

  localparam int dword_width_gp    = 64;
  localparam int cce_block_width_p = 512;
  localparam int paddr_width_p     = 40;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;

  typedef struct packed {
    logic [$clog2(lce_assoc_p)-1:0] way_id;
    logic [lce_id_width_p-1:0]      lce_id;
    logic [2:0]                     size;
    logic [paddr_width_p-1:0]       addr;
    logic [3:0]                     subop;
    logic [3:0]                     msg_type;
  } bp_bedrock_xce_mem_msg_header_s;

  localparam int xce_mem_msg_header_width = $bits(bp_bedrock_xce_mem_msg_header_s);

  function automatic int cfg_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return paddr_width_p;
      default:          return paddr_width_p;
    endcase
  endfunction

endpackage

interface bp_stream_gather_if #(
  parameter int stream_data_width_p = bp_stream_gather_pkg::dword_width_gp,
  parameter int block_width_p       = bp_stream_gather_pkg::cce_block_width_p
) ();

  bp_stream_gather_pkg::bp_bedrock_xce_mem_msg_header_s in_header_i;
  logic [stream_data_width_p-1:0]                       in_data_i;
  logic                                                 in_v_i;
  logic                                                 in_last_i;
  logic                                                 in_ready_and_o;

  bp_stream_gather_pkg::bp_bedrock_xce_mem_msg_header_s out_header_o;
  logic [block_width_p-1:0]                             out_data_o;
  logic                                                 out_v_o;
  logic                                                 out_yumi_i;
  logic                                                 len_err_o;

  modport slave (
    input  in_header_i, in_data_i, in_v_i, in_last_i, out_yumi_i,
    output in_ready_and_o, out_header_o, out_data_o, out_v_o, len_err_o
  );

  modport master (
    output in_header_i, in_data_i, in_v_i, in_last_i, out_yumi_i,
    input  in_ready_and_o, out_header_o, out_data_o, out_v_o, len_err_o
  );

endinterface

// File: rtl/bp_stream_gather.sv
// Gathers a beat stream into one block, wrapping beats inside the size-aligned region and
// replicating that region across the block; presents the result on a valid/yumi port.
//
// state    | meaning
// e_ready  | idle; next accepted beat starts a message and captures its header
// e_gather | collecting beats until the one flagged last
// e_out    | block and header held on the output until yumi
module bp_stream_gather
  import bp_stream_gather_pkg::*;
#(
  parameter bp_params_e  bp_params_p         = e_bp_default_cfg,
  parameter int          stream_data_width_p = dword_width_gp,
  parameter int          block_width_p       = cce_block_width_p,
  parameter logic [15:0] payload_mask_p      = '0
) (
  input logic               clk_i,
  input logic               reset_i,
  bp_stream_gather_if.slave bus
);

  localparam int lp_words   = block_width_p / stream_data_width_p;
  localparam int lp_cnt_w   = (lp_words > 1) ? $clog2(lp_words) : 1;
  localparam int lp_bytes   = stream_data_width_p / 8;
  localparam int lp_off_raw = (lp_bytes > 1) ? $clog2(lp_bytes) : 0;
  localparam int lp_addr_w  = cfg_paddr_width(bp_params_p);
  localparam int lp_off     = (lp_off_raw + lp_cnt_w <= lp_addr_w) ? lp_off_raw : 0;
  localparam int lp_tot_w   = $clog2(lp_words + 2);
  localparam logic [lp_tot_w-1:0] lp_words_c = lp_tot_w'(lp_words);
  localparam logic [lp_tot_w-1:0] lp_sat_c   = lp_tot_w'(lp_words + 1);

  typedef enum logic [1:0] {e_ready, e_gather, e_out} state_e;

  // Beats per message, clamped to [1, words]; a full block therefore masks as all-ones.
  function automatic logic [lp_tot_w-1:0] calc_num(input logic [2:0] size);
    int n;
    n = (1 << size) / lp_bytes;
    if (n < 1) n = 1;
    if (n > lp_words) n = lp_words;
    return lp_tot_w'(n);
  endfunction

  state_e                                          r_state;
  bp_bedrock_xce_mem_msg_header_s                  r_hdr;
  logic [lp_words-1:0][stream_data_width_p-1:0]    r_buf;
  logic [lp_tot_w-1:0]                             r_cnt;
  logic                                            r_out_v;
  logic                                            r_len_err;
  logic                                            r_ready;

  logic [lp_words-1:0][stream_data_width_p-1:0]    w_buf_base;
  logic [lp_words-1:0][stream_data_width_p-1:0]    w_buf_next;
  logic [lp_tot_w-1:0]                             w_cnt_base;
  logic [lp_tot_w-1:0]                             w_total;
  logic [lp_tot_w-1:0]                             w_num;
  logic [lp_tot_w-1:0]                             w_expect;
  logic                                            w_first;
  logic                                            w_accept;
  logic                                            w_payload;
  logic                                            w_wr_en;
  logic [2:0]                                      w_size;
  logic [3:0]                                      w_type;
  logic [lp_cnt_w-1:0]                             w_first_cnt;
  logic [lp_cnt_w-1:0]                             w_mask;
  logic [lp_cnt_w-1:0]                             w_k;
  logic [lp_cnt_w-1:0]                             w_slot;
  logic [stream_data_width_p-1:0]                  w_data;

  // On the first beat the live header decides geometry; afterwards only the captured one does.
  assign w_first     = (r_state == e_ready);
  assign w_accept    = bus.in_v_i & r_ready;
  assign w_size      = w_first ? bus.in_header_i.size     : r_hdr.size;
  assign w_type      = w_first ? bus.in_header_i.msg_type : r_hdr.msg_type;
  assign w_first_cnt = w_first ? bus.in_header_i.addr[lp_off +: lp_cnt_w]
                               : r_hdr.addr[lp_off +: lp_cnt_w];

  assign w_num      = calc_num(w_size);
  assign w_mask     = lp_cnt_w'(w_num - 1'b1);
  assign w_payload  = payload_mask_p[w_type];
  assign w_cnt_base = w_first ? '0 : r_cnt;
  assign w_k        = w_cnt_base[lp_cnt_w-1:0];
  assign w_wr_en    = (w_cnt_base < lp_words_c);
  assign w_slot     = (w_first_cnt + w_k) & w_mask;
  assign w_total    = (w_cnt_base == lp_sat_c) ? lp_sat_c : w_cnt_base + 1'b1;
  assign w_expect   = w_payload ? w_num : lp_tot_w'(1);
  assign w_data     = w_payload ? bus.in_data_i : '0;
  assign w_buf_base = w_first ? '0 : r_buf;

  // Writing every word whose low bits match the slot keeps the block replicated at all times.
  always_comb begin
    w_buf_next = w_buf_base;
    if (w_wr_en) begin
      for (int j = 0; j < lp_words; j++) begin
        if ((lp_cnt_w'(j) & w_mask) == w_slot) w_buf_next[j] = w_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= e_ready;
      r_hdr     <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_out_v   <= 1'b0;
      r_len_err <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        e_ready, e_gather: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_first) r_hdr <= bus.in_header_i;
            r_buf <= w_buf_next;
            r_cnt <= w_total;
            if (bus.in_last_i) begin
              r_state   <= e_out;
              r_out_v   <= 1'b1;
              r_len_err <= (w_total != w_expect);
              r_ready   <= 1'b0;
            end else begin
              r_state <= e_gather;
            end
          end
        end
        e_out: begin
          if (bus.out_yumi_i) begin
            r_state   <= e_ready;
            r_out_v   <= 1'b0;
            r_len_err <= 1'b0;
            r_ready   <= 1'b1;
          end
        end
        default: r_state <= e_ready;
      endcase
    end
  end

  assign bus.in_ready_and_o = r_ready;
  assign bus.out_header_o   = r_hdr;
  assign bus.out_data_o     = r_buf;
  assign bus.out_v_o        = r_out_v;
  assign bus.len_err_o      = r_len_err;

endmodule

// File: tb/tb_bp_stream_gather.sv
// Directed bench for bp_stream_gather: stimulus pushes hand-computed results into a
// scoreboard queue, an independent sink drains the DUT output and compares.
module tb_bp_stream_gather;

  typedef bp_stream_gather_pkg::bp_bedrock_xce_mem_msg_header_s hdr_t;

  typedef struct {
    hdr_t         hdr;
    logic [511:0] data;
    logic         err;
  } exp_t;

  logic clk;
  logic reset_i;

  bp_stream_gather_if #(.stream_data_width_p(64), .block_width_p(512)) bus ();

  bp_stream_gather #(
    .stream_data_width_p(64),
    .block_width_p(512),
    .payload_mask_p(16'h000A)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          yumi_delay = 0;
  exp_t        sb_q[$];
  logic [63:0] beats[16];
  hdr_t        junk_hdr;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic hdr_t mk_hdr(input logic [3:0] t, input logic [39:0] a,
                                  input logic [2:0] sz, input logic [3:0] id);
    hdr_t h;
    h          = '0;
    h.msg_type = t;
    h.subop    = 4'h6;
    h.addr     = a;
    h.size     = sz;
    h.lce_id   = id;
    h.way_id   = 3'd5;
    return h;
  endfunction

  task automatic fill(input logic [31:0] tag);
    for (int i = 0; i < 16; i++) beats[i] = {tag, 32'(i)};
  endtask

  task automatic push(input hdr_t h, input logic [511:0] d, input logic e);
    exp_t x;
    x.hdr  = h;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Beats after the first carry junk_hdr, which the DUT must ignore.
  task automatic send(input hdr_t h, input int n, input int abort_at);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_v_i      = 1'b1;
      bus.in_last_i   = (i == n - 1);
      bus.in_header_i = (i == 0) ? h : junk_hdr;
      bus.in_data_i   = beats[i];
      t = 0;
      while (!bus.in_ready_and_o) begin
        @(negedge clk);
        t++;
        if (t > 200) begin
          $display("FAIL send_timeout: beat %0d never accepted", i);
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk);
      if (abort_at != 0 && i == abort_at - 1) begin
        #2 reset_i = 1'b0;
        #1;
        chk("rst_async_out_v", 512'(bus.out_v_o), 512'h0);
        chk("rst_async_ready", 512'(bus.in_ready_and_o), 512'h0);
        bus.in_v_i    = 1'b0;
        bus.in_last_i = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.in_v_i    = 1'b0;
    bus.in_last_i = 1'b0;
    chk("out_v_latency", 512'(bus.out_v_o), 512'h1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 512'(sb_q.size()), 512'h0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Output sink / scoreboard monitor.
  initial begin
    int   hold;
    bit   post_pop;
    exp_t e;
    hold     = 0;
    post_pop = 0;
    bus.out_yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      if (post_pop) begin
        post_pop = 0;
        if (reset_i) chk("ready_after_yumi", 512'(bus.in_ready_and_o), 512'h1);
      end
      bus.out_yumi_i = 1'b0;
      if (reset_i && bus.out_v_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_v", 512'(bus.out_v_o), 512'h0);
          bus.out_yumi_i = 1'b1;
        end else if (hold < yumi_delay) begin
          hold++;
          chk("hold_ready", 512'(bus.in_ready_and_o), 512'h0);
          chk("hold_header", 512'(bus.out_header_o), 512'(sb_q[0].hdr));
          chk("hold_data", bus.out_data_o, sb_q[0].data);
        end else begin
          e = sb_q.pop_front();
          chk("out_header", 512'(bus.out_header_o), 512'(e.hdr));
          chk("out_data", bus.out_data_o, e.data);
          chk("len_err", 512'(bus.len_err_o), 512'(e.err));
          bus.out_yumi_i = 1'b1;
          hold     = 0;
          post_pop = 1;
        end
      end
    end
  end

  initial begin
    hdr_t h;
    reset_i         = 1'b0;
    bus.in_v_i      = 1'b0;
    bus.in_last_i   = 1'b0;
    bus.in_header_i = '0;
    bus.in_data_i   = '0;
    junk_hdr        = mk_hdr(4'h3, 40'hFF_FFFF_FFF8, 3'd2, 4'hF);

    #3;
    chk("rst_out_v", 512'(bus.out_v_o), 512'h0);
    chk("rst_len_err", 512'(bus.len_err_o), 512'h0);
    chk("rst_ready", 512'(bus.in_ready_and_o), 512'h0);
    chk("rst_header", 512'(bus.out_header_o), 512'h0);
    chk("rst_data", bus.out_data_o, 512'h0);
    repeat (2) @(negedge clk);
    chk("rst_ready_clocked", 512'(bus.in_ready_and_o), 512'h0);
    reset_i = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 512'(bus.in_ready_and_o), 512'h1);

    // Full-block wrap: first_cnt 2, words 2..7,0,1 = D0..D7.
    fill(32'hD0D0_0000);
    h = mk_hdr(4'h1, 40'h10_0000_0010, 3'd6, 4'h2);
    push(h, {beats[5], beats[4], beats[3], beats[2], beats[1], beats[0], beats[7], beats[6]}, 1'b0);
    send(h, 8, 0);

    // Sub-block wrap: 32B at first_cnt 3, words 3,0,1,2 = A,B,C,D, replicated.
    fill(32'hA0B0_C0D0);
    h = mk_hdr(4'h1, 40'h00_0000_2018, 3'd5, 4'h3);
    push(h, {beats[0], beats[3], beats[2], beats[1], beats[0], beats[3], beats[2], beats[1]}, 1'b0);
    send(h, 4, 0);

    // Non-payload type: single beat clean, two beats length error; data always zero.
    fill(32'h5555_AAAA);
    h = mk_hdr(4'h0, 40'h00_0000_0040, 3'd3, 4'h4);
    push(h, 512'h0, 1'b0);
    send(h, 1, 0);
    h = mk_hdr(4'h0, 40'h00_0000_0048, 3'd3, 4'h7);
    push(h, 512'h0, 1'b1);
    send(h, 2, 0);
    wait_drain();

    // Backpressure: 16B at first_cnt 1, output held five cycles.
    yumi_delay = 5;
    fill(32'hE0E0_0000);
    h = mk_hdr(4'h3, 40'h00_0000_3008, 3'd4, 4'h9);
    push(h, {beats[0], beats[1], beats[0], beats[1], beats[0], beats[1], beats[0], beats[1]}, 1'b0);
    send(h, 2, 0);
    wait_drain();
    yumi_delay = 0;

    // Early last on beat 4 of a 64B message: upper words stay zero.
    fill(32'hF0F0_0000);
    h = mk_hdr(4'h1, 40'h00_0000_0000, 3'd6, 4'h1);
    push(h, {256'h0, beats[3], beats[2], beats[1], beats[0]}, 1'b1);
    send(h, 4, 0);

    // Ten beats into an 8-word block: the extra two are dropped but flagged.
    fill(32'h6060_0000);
    h = mk_hdr(4'h3, 40'h00_0000_0100, 3'd6, 4'hA);
    push(h, {beats[7], beats[6], beats[5], beats[4], beats[3], beats[2], beats[1], beats[0]}, 1'b1);
    send(h, 10, 0);
    wait_drain();

    // Reset after beat 3 of 8; nothing may come out of the aborted message.
    fill(32'h7777_0000);
    h = mk_hdr(4'h1, 40'h00_0000_0010, 3'd6, 4'h2);
    send(h, 8, 3);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 512'(bus.in_ready_and_o), 512'h1);

    // Fresh one-beat 64B message at first_cnt 5: only word 5 set, no residue.
    fill(32'h8888_0000);
    h = mk_hdr(4'h1, 40'h00_0000_0028, 3'd6, 4'hC);
    push(h, {128'h0, beats[0], 320'h0}, 1'b1);
    send(h, 1, 0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
